vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single-port VRAM (CPU window 0x4000-0x5fff, 13-bit word address) between the CPU data port and the display scan-out reader.
- Display reads have priority. A run-length guard bounds CPU starvation.
- Produces the CPU-side busy signal. Returns read data to each requester with a fixed RAM latency.
- Sits between the cpu data port, the display line fetcher and the VRAM macro.

Parameters:
ADDR_W, 13, VRAM word-address width
DATA_W, 16, data width
RD_LAT, 1, RAM read latency in cycles (legal 1 or 2)
MAX_RUN, 4, max consecutive display grants while a CPU access is pending (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset (asserted when 0)
cpu_re  input  1  CPU read request (level, held until served)
cpu_we  input  1  CPU write request (level, held until served)
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_busy  output  1  1 = CPU request not served this cycle
cpu_rdata  output  DATA_W  last CPU read result, held until next CPU read returns
disp_req  input  1  display read request (level)
disp_addr  input  ADDR_W  display word address
disp_ack  output  1  pulse: display read issued this cycle, fetcher may advance address
disp_valid  output  1  pulse: disp_rdata valid
disp_rdata  output  DATA_W  display read data
ram_addr  output  ADDR_W  VRAM address
ram_wdata  output  DATA_W  VRAM write data
ram_we  output  1  VRAM write strobe
ram_rdata  input  DATA_W  VRAM read data, RD_LAT cycles after address

Behaviour:
- cpu_pend = cpu_re | cpu_we. cpu_we has precedence if both are high.
- Counter run (0..MAX_RUN), registered.
- cpu_busy = disp_req & (run != MAX_RUN). Combinational. Must not depend on cpu_re/cpu_we (no comb loop through the CPU).
- Grant, per cycle, combinational:
  - DISP if disp_req & (run != MAX_RUN).
  - else CPU if cpu_pend.
  - else NONE.
- DISP grant: ram_addr = disp_addr, ram_we = 0, disp_ack = 1, tag a display read into the RD_LAT-deep return pipe.
- CPU grant:
  - ram_addr = cpu_addr.
  - Write: ram_we = 1, ram_wdata = cpu_wdata. Write completes the same cycle.
  - Read: tag a CPU read into the return pipe.
- NONE: ram_addr = cpu_addr, ram_we = 0, disp_ack = 0.
- run update:
  - DISP grant & cpu_pend -> run + 1 (saturates at MAX_RUN).
  - CPU grant or !cpu_pend -> 0.
  - Otherwise hold.
- Return pipe: 2-bit tag {disp, cpu} shifted RD_LAT stages. On exit:
  - disp tag -> disp_valid = 1, disp_rdata = ram_rdata (registered).
  - cpu tag -> cpu_rdata <= ram_rdata.
- Latency:
  - CPU read data lands in cpu_rdata RD_LAT+1 edges after the grant cycle, i.e. within the CPU's 2-cycle post-busy wait for RD_LAT=1.
  - disp_valid asserts RD_LAT+1 cycles after disp_ack.
- Simultaneous requests with run < MAX_RUN: display wins, CPU stalls.
- At run == MAX_RUN: CPU is granted even though disp_req is high. disp_ack = 0 that cycle. run -> 0.
- cpu_busy low with no CPU request: slot unused; display is not granted at run == MAX_RUN.
- Address range: the arbiter does not decode; only VRAM-window accesses reach it.
- Reset low, asynchronously:
  - Pipe tags, run, disp_valid, disp_rdata and cpu_rdata cleared to 0.
  - ram_we, disp_ack forced 0; cpu_busy forced 1.
  - In-flight reads are discarded. No disp_valid pulse after reset release for reads issued before it.

Test Plan:
1. Reset: hold reset=0 with disp_req=1, cpu_we=1 -> ram_we=0, disp_ack=0, cpu_busy=1, disp_valid=0, cpu_rdata=0x0000.
2. CPU write alone: cpu_we=1, addr 0x0123, wdata 0xBEEF, disp_req=0 -> same cycle ram_we=1, ram_addr=0x0123, ram_wdata=0xBEEF, cpu_busy=0.
3. CPU read alone, RD_LAT=1: RAM holds 0x1234 at 0x0042; cpu_re=1 -> cpu_busy=0, cpu_rdata=0x1234 two edges after the grant cycle.
4. Display stream: disp_req=1 for 8 cycles, addresses 0x0000..0x0007, CPU idle -> 8 disp_ack pulses, 8 disp_valid pulses each lagging its ack by 2 cycles, data in order.
5. Starvation guard, MAX_RUN=4: disp_req=1 continuous, cpu_we=1 from cycle 0 -> cpu_busy=1 cycles 0-3, cycle 4 cpu_busy=0 with ram_we=1 and disp_ack=0, display resumes cycle 5.
6. Reset mid-read: display read issued, reset=0 the next cycle for 1 cycle -> no disp_valid after release, run=0, next disp_req granted immediately.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle around the VRAM arbiter: CPU data port, display fetcher port and VRAM macro port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    // CPU data port
    logic              cpu_re;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic [DATA_W-1:0] cpu_rdata;

    // Display line fetcher
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_rdata;

    // VRAM macro
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_rdata,
        input  disp_req, disp_addr,
        output disp_ack, disp_valid, disp_rdata,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_rdata,
        output disp_req, disp_addr,
        input  disp_ack, disp_valid, disp_rdata,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads win, but after MAX_RUN display grants against a
// waiting CPU access the CPU gets one slot. Read data returns through a tagged RD_LAT pipe.
module vram_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1,
    parameter int MAX_RUN = 4
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);

    generate
        if (RD_LAT < 1 || RD_LAT > 2 || MAX_RUN < 1) begin : g_bad_params
            $error("vram_arbiter: RD_LAT must be 1 or 2 and MAX_RUN must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_CPU
    } grant_e;

    // One return-pipe slot: which requester (if any) owns the RAM data leaving this stage.
    typedef struct packed {
        logic disp;
        logic cpu;
    } tag_t;

    grant_e            grant;
    logic              cpu_pend;
    logic              disp_win;
    logic [ADDR_W-1:0] addr_sel;
    tag_t              tag_exit;

    logic [RUN_W-1:0]  run_q, run_d;
    tag_t [RD_LAT-1:0] pipe_q, pipe_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    // Grant decision. disp_win is deliberately independent of the CPU request lines so that
    // cpu_busy has no combinational path back from cpu_re/cpu_we.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        grant    = GNT_NONE;
        cpu_pend = bus.cpu_re | bus.cpu_we;
        disp_win = bus.disp_req && (run_q != RUN_LIMIT);
        if (disp_win) begin
            grant = GNT_DISP;
        end else if (cpu_pend) begin
            grant = GNT_CPU;
        end
    end

    always_comb begin
        addr_sel = bus.cpu_addr;
        if (grant == GNT_DISP) begin
            addr_sel = bus.disp_addr;
        end
    end

    // Reset forces the strobes idle and holds the CPU off, independent of the clock.
    assign bus.ram_addr   = addr_sel;
    assign bus.ram_wdata  = bus.cpu_wdata;
    assign bus.ram_we     = reset && (grant == GNT_CPU) && bus.cpu_we;
    assign bus.disp_ack   = reset && (grant == GNT_DISP);
    assign bus.cpu_busy   = !reset || disp_win;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_rdata = disp_rdata_q;

    // run counts display grants taken while the CPU is waiting; any CPU slot or an idle CPU
    // clears it. A display grant implies run < MAX_RUN, so the increment cannot overflow.
    always_comb begin
        run_d = run_q;
        if (grant == GNT_DISP && cpu_pend) begin
            run_d = run_q + RUN_W'(1);
        end else if (grant == GNT_CPU || !cpu_pend) begin
            run_d = '0;
        end
    end

    // Return pipe: a tag enters with the address and leaves when the RAM data is on ram_rdata.
    always_comb begin
        pipe_d         = pipe_q;
        pipe_d[0].disp = (grant == GNT_DISP);
        pipe_d[0].cpu  = (grant == GNT_CPU) && !bus.cpu_we;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign tag_exit = pipe_q[RD_LAT-1];

    always_comb begin
        disp_valid_d = tag_exit.disp;
        disp_rdata_d = disp_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        if (tag_exit.disp) begin
            disp_rdata_d = bus.ram_rdata;
        end
        if (tag_exit.cpu) begin
            cpu_rdata_d = bus.ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the return-pipe tags are reset along with the counters; clearing them is
            // what discards reads that were in flight when reset hit.
            run_q        <= '0;
            pipe_q       <= '0;
            disp_valid_q <= 1'b0;
            disp_rdata_q <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            run_q        <= run_d;
            pipe_q       <= pipe_d;
            disp_valid_q <= disp_valid_d;
            disp_rdata_q <= disp_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

endmodule
